seq_stuff_tx: RTL
=================

SEQ_STUFF_TX -- requirements
Module: seq_stuff_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the byte width loaded per transfer.
REQ-002 SHALL have parameter RUN_LEN, default 5, the number of identical consecutive output bits that triggers a stuff bit.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port load, input, 1, the request to accept din.
REQ-006 SHALL have port din, input, DATA_W, the parallel data byte.
REQ-007 SHALL have port ready, output, 1, high when a load is accepted this cycle.
REQ-008 SHALL have port dout, output, 1, the serial bit stream; idle level 1 (recessive).
REQ-009 SHALL have port dout_valid, output, 1, high on every cycle in which dout carries a data or stuff bit.
REQ-010 SHALL have port is_stuff, output, 1, high when the current dout bit is an inserted stuff bit.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse after the final bit of a stream.

Function
REQ-012 SHALL use states IDLE, SHIFT and STUFF.
REQ-013 SHALL accept a load when load&&ready; din is captured and its MSB appears on dout in the next cycle (latency 1), MSB first.
REQ-014 SHALL drive ready high in IDLE, and in SHIFT during the last data bit of the current byte; otherwise low.
REQ-015 SHALL ignore load while ready is low, with no state change.
REQ-016 SHALL hold a run counter (width clog2(RUN_LEN)+1) of identical consecutive emitted bits, stuff bits included; a stuff bit starts a new run of 1.
REQ-017 SHALL go SHIFT->STUFF after emitting the bit that brings the run to RUN_LEN; in STUFF it SHALL emit ~previous bit with is_stuff=1, hold the shift register, then return to SHIFT, or to IDLE if no bits or byte remain.
REQ-018 SHALL, on a load accepted during the last data bit, continue the stream without a gap; a required trailing stuff bit is emitted before the new byte's MSB, and the run counter carries across bytes.
REQ-019 SHALL emit a required trailing stuff bit before IDLE when no byte follows.
REQ-020 SHALL, on entering IDLE, pulse done for one cycle, drive dout=1 and dout_valid=0, and clear the run counter.

Reset
REQ-021 SHALL, while rst is high, force state IDLE, ready=1, dout=1, dout_valid=0, is_stuff=0, done=0, run counter=0, and shift register=0.
REQ-022 SHALL abort any stream on rst mid-operation; done SHALL NOT pulse for the aborted stream.

Configuration
REQ-023 SHALL, with macro SEQ_STUFF_EN defined, perform bit stuffing as in REQ-016..REQ-019.
REQ-024 SHALL, without SEQ_STUFF_EN, omit the STUFF state and run counter, tie is_stuff to 0, and act as a plain serializer emitting DATA_W bits per byte.

Structure
REQ-025 SHALL take the state encoding typedef and the idle-level constant (1'b1) from shared package seq_pkg.
REQ-026 SHALL place the run counter and stuff-decision logic in one sub-module, seq_run_cnt; the FSM and shift register SHALL remain in seq_stuff_tx.

Verification
REQ-027 Bench SHALL check: load 0xA5 in IDLE -> dout 1,0,1,0,0,1,0,1 over 8 valid cycles, is_stuff never high, done pulse on cycle 9.
REQ-028 Bench SHALL check: load 0xFF -> dout 1,1,1,1,1,0(stuff),1,1,1 over 9 valid cycles, is_stuff only on cycle 6.
REQ-029 Bench SHALL check: back-to-back 0x00, 0x00 (second load on the last bit) -> 0,0,0,0,0,S1,0,0,0 then 0,0,S1,0,0,0,0,0,S1,0 with no gap, a single done at the end.
REQ-030 Bench SHALL check: load asserted in mid-byte -> ignored, the byte completes unchanged.
REQ-031 Bench SHALL check: rst at bit 4 of 0xFF -> next cycle dout=1, dout_valid=0, ready=1, no done; a new load of 0xA5 then behaves per REQ-027.
REQ-032 Bench SHALL check, without SEQ_STUFF_EN: load 0xFF -> eight 1s, is_stuff=0, done on cycle 9.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the stuffing serializer.
// SEQ_STUFF_EN adds the STUFF state; without it the FSM is a plain serializer.
package seq_pkg;

  localparam logic IDLE_LVL = 1'b1;

`ifdef SEQ_STUFF_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/seq_run_cnt.sv
// Run-length tracker for the emitted bit stream; flags when a stuff bit is due.
// Only instantiated when SEQ_STUFF_EN is defined.
module seq_run_cnt #(
  parameter int unsigned RUN_LEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic emit_i,
  input  logic bit_i,
  output logic stuff_req_o,
  output logic stuff_bit_o
);

  localparam int unsigned CW = $clog2(RUN_LEN) + 1;

  logic [CW-1:0] run_q, run_d;
  logic          last_q, last_d;

  // A stuff bit always differs from the previous bit, so it naturally restarts the run at 1.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clear_i) begin
      run_d = '0;
    end else if (emit_i) begin
      last_d = bit_i;
      if ((run_q != '0) && (bit_i == last_q)) begin
        run_d = run_q + CW'(1);
      end else begin
        run_d = CW'(1);
      end
    end
  end

  assign stuff_req_o = emit_i && !clear_i && (run_d == CW'(RUN_LEN));
  assign stuff_bit_o = ~last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seq_stuff_tx.sv
// MSB-first parallel-to-serial transmitter with optional bit stuffing.
// Define SEQ_STUFF_EN to insert a complement bit after RUN_LEN identical bits.
module seq_stuff_tx
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RUN_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              is_stuff,
  output logic              done
);

  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     idx_q, idx_d;
  logic              done_q, done_d;
  logic              last_bit;

  assign last_bit = (idx_q == BW'(DATA_W - 1));

`ifdef SEQ_STUFF_EN
  // more_q: a data bit (current byte or a byte loaded on the last bit) follows the stuff bit.
  logic more_q, more_d;
  logic stuff_req, stuff_bit, emit_bit;

  assign emit_bit = (state_q == STUFF) ? stuff_bit : sh_q[DATA_W-1];

  seq_run_cnt #(
    .RUN_LEN(RUN_LEN)
  ) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == IDLE),
    .emit_i     (state_q != IDLE),
    .bit_i      (emit_bit),
    .stuff_req_o(stuff_req),
    .stuff_bit_o(stuff_bit)
  );
`endif

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    ready      = 1'b1;
    dout       = IDLE_LVL;
    dout_valid = 1'b0;
    is_stuff   = 1'b0;
`ifdef SEQ_STUFF_EN
    more_d     = more_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = din;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ready      = last_bit;
        dout       = sh_q[DATA_W-1];
        dout_valid = 1'b1;
        if (last_bit && load) begin
          sh_d  = din;
          idx_d = '0;
        end else begin
          sh_d  = sh_q << 1;
          idx_d = idx_q + BW'(1);
        end
`ifdef SEQ_STUFF_EN
        more_d = !last_bit || load;
        if (stuff_req) begin
          state_d = STUFF;
        end else if (last_bit && !load) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        if (last_bit && !load) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end
`ifdef SEQ_STUFF_EN
      STUFF: begin
        ready      = 1'b0;
        dout       = stuff_bit;
        dout_valid = 1'b1;
        is_stuff   = 1'b1;
        if (more_q) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Reset forces the idle interface immediately, not just after the clock edge.
    if (rst) begin
      ready      = 1'b1;
      dout       = IDLE_LVL;
      dout_valid = 1'b0;
      is_stuff   = 1'b0;
    end
  end

  assign done = done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_STUFF_EN
      more_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef SEQ_STUFF_EN
      more_q  <= more_d;
`endif
    end
  end

endmodule
